pht_update_scheduler: RTL and testbench
=======================================

Name: pht_update_scheduler

Overview:
- Sits between the branch-resolution ports and the write ports of the multibank pattern-history table (PHT).
- Buffers counter-update requests in an in-order queue. Issues up to WR_NUM writes per cycle, never two writes to the same bank in one cycle, so no conflicting update is silently discarded.
- Also sequences PHT initialisation after reset or on request, writing INIT_VALUE to every entry through write port 0.

Parameters:
- ENTRY_NUM, 1024, PHT entries; power of two.
- INDEX_W, 10, log2(ENTRY_NUM).
- DATA_W, 8, PHT entry width (packed counters).
- BANK_NUM, 2, PHT banks; power of two; bank = index[log2(BANK_NUM)-1:0].
- REQ_NUM, 2, update request ports (INT_ISSUE_WIDTH).
- WR_NUM, 2, PHT write ports; must be ≤ BANK_NUM.
- QUEUE_DEPTH, 8, update queue entries; power of two.
- INIT_VALUE, 8'hAA, entry value written during initialisation (each 2-bit counter = weakly taken).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- init_req  in  1  synchronous; restarts initialisation and flushes the queue.
- req_valid  in  REQ_NUM  update request valid per port.
- req_index  in  REQ_NUM*INDEX_W  PHT index per port.
- req_data  in  REQ_NUM*DATA_W  new entry value per port.
- wr_en  out  WR_NUM  PHT write enable per port.
- wr_addr  out  WR_NUM*INDEX_W  PHT write address.
- wr_data  out  WR_NUM*DATA_W  PHT write data.
- init_busy  out  1  high while initialisation is in progress.
- drop_pulse  out  1  one-cycle pulse when ≥1 request is dropped because the queue is full.
- occupancy  out  log2(QUEUE_DEPTH)+1  queued entries.

Behaviour:
- Reset (async): state=INIT, init_idx=0, queue empty. Outputs: wr_en=0, init_busy=1, drop_pulse=0, occupancy=0.
- FSM states:
  - INIT: each cycle drive wr_en[0]=1, wr_addr[0]=init_idx, wr_data[0]=INIT_VALUE; other wr_en=0; init_idx++. When init_idx==ENTRY_NUM-1 has been written, go to RUN. init_busy=1 throughout. req_valid is ignored (not queued, not counted as a drop).
  - RUN: normal scheduling; init_busy=0.
  - init_req=1 in any state: next cycle INIT, init_idx=0, queue flushed. An init_req during INIT restarts the sweep at 0.
- Issue (RUN only): wr_* are driven combinationally from registered queue state only, never from req_*.
  - Slot k (k<WR_NUM) issues queue entry head+k only if slots 0..k-1 issued and its bank differs from every earlier slot's bank this cycle. Issue stops at the first conflict or empty entry; strict FIFO order.
  - Issued entries are popped the same cycle.
- Enqueue:
  - Requests are accepted in port order 0..REQ_NUM-1.
  - Free space = QUEUE_DEPTH − occupancy + pops this cycle.
  - Requests beyond free space are dropped, and drop_pulse=1 next cycle.
  - Earliest write of a request accepted in cycle N is cycle N+1 (1-cycle latency).
- Ordering: two updates to the same index are always in the same bank, so they issue in arrival order in different cycles. Last writer wins.
- Pointers wrap modulo QUEUE_DEPTH. occupancy is updated as push_count − pop_count, registered.
- Simultaneous full queue + pop + push: freed slots are reusable in the same cycle.

Optional Feature:
- Macro: PHT_SCHED_COALESCE_EN.
- Defined:
  - An accepted request whose index equals a queued, not-issuing-this-cycle entry overwrites that entry's data in place. No new slot is used and occupancy is unchanged.
  - Two same-cycle requests with equal index: the higher port wins, and only one slot is used.
  - Coalesced requests never cause drop_pulse.
- Undefined: every accepted request takes its own slot; no index comparison logic is built.

Test Plan:
- Release rst, hold idle → wr_en[0]=1 with addresses 0..1023 and data 8'hAA for 1024 cycles, init_busy falls the cycle after address 1023, then wr_en=0.
- RUN, one cycle of req_valid=2'b11, indices 0x004 and 0x005 (banks 0 and 1) → next cycle wr_en=2'b11, wr_addr[0]=0x004, wr_addr[1]=0x005, occupancy returns to 0.
- RUN, one cycle of indices 0x006 and 0x008 (both bank 0) → cycle+1 only wr_en[0] with addr 0x006; cycle+2 wr_en[0] with addr 0x008.
- RUN, 10 back-to-back cycles of same-bank pairs at distinct indices (no coalesce) → occupancy saturates at 8, drop_pulse asserts, exactly 1 write per cycle, written order equals accepted arrival order.
- Assert init_req mid-RUN with occupancy=5 → next cycle occupancy=0, init_busy=1, sweep restarts at address 0; queued updates are never written.
- With PHT_SCHED_COALESCE_EN, index 0x010 data 0x11 then index 0x010 data 0x22 while the first is blocked by a bank conflict → single write of 0x22 to 0x010, occupancy peaks at 1 for that index.

Source files
------------

// File: rtl/pht_update_scheduler_if.sv
// ---------------------------------------------------------------------------
// pht_update_scheduler_if
//
// Bundles the request side and the PHT write side of the PHT update
// scheduler. The requester/bench uses the master modport and the scheduler
// uses the slave modport.
//
// Signals:
//   init_req    master->slave  restart initialisation and flush the queue
//   req_valid   master->slave  [REQ_NUM]          update request valid per port
//   req_index   master->slave  [REQ_NUM*INDEX_W]  PHT index per port
//   req_data    master->slave  [REQ_NUM*DATA_W]   new entry value per port
//   wr_en       slave->master  [WR_NUM]           PHT write enable per port
//   wr_addr     slave->master  [WR_NUM*INDEX_W]   PHT write address
//   wr_data     slave->master  [WR_NUM*DATA_W]    PHT write data
//   init_busy   slave->master  initialisation in progress
//   drop_pulse  slave->master  one-cycle pulse when a request was dropped
//   occupancy   slave->master  [log2(QUEUE_DEPTH)+1] queued entries
// ---------------------------------------------------------------------------
interface pht_update_scheduler_if #(
   parameter int INDEX_W     = 10,
   parameter int DATA_W      = 8,
   parameter int REQ_NUM     = 2,
   parameter int WR_NUM      = 2,
   parameter int QUEUE_DEPTH = 8
) ();
   localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

   logic                        init_req;
   logic [REQ_NUM-1:0]          req_valid;
   logic [REQ_NUM*INDEX_W-1:0]  req_index;
   logic [REQ_NUM*DATA_W-1:0]   req_data;
   logic [WR_NUM-1:0]           wr_en;
   logic [WR_NUM*INDEX_W-1:0]   wr_addr;
   logic [WR_NUM*DATA_W-1:0]    wr_data;
   logic                        init_busy;
   logic                        drop_pulse;
   logic [CNT_W-1:0]            occupancy;

   modport master (
      output init_req, req_valid, req_index, req_data,
      input  wr_en, wr_addr, wr_data, init_busy, drop_pulse, occupancy
   );

   modport slave (
      input  init_req, req_valid, req_index, req_data,
      output wr_en, wr_addr, wr_data, init_busy, drop_pulse, occupancy
   );
endinterface

// File: rtl/pht_update_scheduler.sv
// ---------------------------------------------------------------------------
// pht_update_scheduler
//
// Buffers PHT counter updates in an in-order queue and issues up to WR_NUM
// writes per cycle, never two to the same bank in one cycle. After reset or
// on init_req it sweeps every PHT entry with INIT_VALUE through write port 0.
//
// Ports:
//   clk  clock
//   rst  asynchronous reset, active-high
//   bus  pht_update_scheduler_if.slave (requests in, PHT writes and status out)
//
// Optional feature (macro PHT_SCHED_COALESCE_EN): an accepted request whose
// index matches a queued entry that is not issuing this cycle, or an earlier
// same-cycle request, overwrites that entry's data instead of taking a slot.
// ---------------------------------------------------------------------------
module pht_update_scheduler #(
   parameter int               ENTRY_NUM   = 1024,
   parameter int               INDEX_W     = 10,
   parameter int               DATA_W      = 8,
   parameter int               BANK_NUM    = 2,
   parameter int               REQ_NUM     = 2,
   parameter int               WR_NUM      = 2,
   parameter int               QUEUE_DEPTH = 8,
   parameter logic [DATA_W-1:0] INIT_VALUE = 8'hAA
) (
   input  logic                     clk,
   input  logic                     rst,
   pht_update_scheduler_if.slave    bus
);
   localparam int PTR_W = $clog2(QUEUE_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [INDEX_W-1:0] BANK_MASK = INDEX_W'(BANK_NUM - 1);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t               state;
   logic [INDEX_W-1:0]   init_idx;
   logic [PTR_W-1:0]     head, tail;
   logic [CNT_W-1:0]     occ;
   logic                 init_busy, drop_pulse;

   logic [INDEX_W-1:0]   q_index [QUEUE_DEPTH];
   logic [DATA_W-1:0]    q_data  [QUEUE_DEPTH];

   logic [INDEX_W-1:0]   req_idx [REQ_NUM];
   logic [DATA_W-1:0]    req_dat [REQ_NUM];

   logic [PTR_W-1:0]     slot_ptr  [WR_NUM];
   logic [INDEX_W-1:0]   slot_bank [WR_NUM];
   logic [WR_NUM-1:0]    issue;
   logic [CNT_W-1:0]     pop_cnt, push_cnt;

   logic [REQ_NUM-1:0]   push_en, coal_en;
   logic [PTR_W-1:0]     push_ptr [REQ_NUM];
   logic [PTR_W-1:0]     coal_ptr [REQ_NUM];
   logic                 any_drop;
   logic                 accept_ok;

   logic [WR_NUM-1:0]          wr_en;
   logic [WR_NUM*INDEX_W-1:0]  wr_addr;
   logic [WR_NUM*DATA_W-1:0]   wr_data;

   for (genvar p = 0; p < REQ_NUM; p++) begin : g_req
      assign req_idx[p] = bus.req_index[p*INDEX_W +: INDEX_W];
      assign req_dat[p] = bus.req_data[p*DATA_W +: DATA_W];
   end

   // Candidate entries for each write slot, taken from the queue head onward.
   always_comb begin
      for (int k = 0; k < WR_NUM; k++) begin
         slot_ptr[k]  = head + PTR_W'(k);
         slot_bank[k] = q_index[head + PTR_W'(k)] & BANK_MASK;
      end
   end

   // Strict FIFO issue: a slot goes only if every earlier slot went and its
   // bank is not already taken this cycle; the first miss stops the chain.
   always_comb begin : issue_logic
      logic go;
      // NOTE: every combinational output gets a default before any branch so
      // no path leaves it unassigned and no latch is inferred.
      go      = (state == ST_RUN);
      issue   = '0;
      pop_cnt = '0;
      for (int k = 0; k < WR_NUM; k++) begin
         if (CNT_W'(k) >= occ) go = 1'b0;
         for (int j = 0; j < k; j++)
            if (slot_bank[j] == slot_bank[k]) go = 1'b0;
         issue[k] = go;
         if (go) pop_cnt = pop_cnt + CNT_W'(1);
      end
   end

   // Write ports are driven from registered state only. The rst term keeps
   // the sweep from appearing on the port while reset is held.
   always_comb begin
      wr_en   = '0;
      wr_addr = '0;
      wr_data = '0;
      if (state == ST_INIT) begin
         wr_en[0]                = !rst;
         wr_addr[INDEX_W-1:0]    = init_idx;
         wr_data[DATA_W-1:0]     = INIT_VALUE;
      end else begin
         for (int k = 0; k < WR_NUM; k++) begin
            if (issue[k]) begin
               wr_en[k]                       = 1'b1;
               wr_addr[k*INDEX_W +: INDEX_W]  = q_index[slot_ptr[k]];
               wr_data[k*DATA_W +: DATA_W]    = q_data[slot_ptr[k]];
            end
         end
      end
   end

   assign accept_ok = (state == ST_RUN) && !bus.init_req;

   // Requests are taken in port order; slots popped this cycle are free again.
   always_comb begin : enqueue_logic
      logic [CNT_W-1:0] free;
      logic [CNT_W-1:0] used;
`ifdef PHT_SCHED_COALESCE_EN
      logic [PTR_W-1:0] off;
`endif
      free     = CNT_W'(QUEUE_DEPTH) - occ + pop_cnt;
      used     = '0;
      push_en  = '0;
      coal_en  = '0;
      push_ptr = '{default: '0};
      coal_ptr = '{default: '0};
      any_drop = 1'b0;
`ifdef PHT_SCHED_COALESCE_EN
      off      = '0;
`endif
      for (int p = 0; p < REQ_NUM; p++) begin
         if (accept_ok && bus.req_valid[p]) begin
`ifdef PHT_SCHED_COALESCE_EN
            // Entries already on the write ports this cycle cannot be merged into.
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
               off = PTR_W'(i) - head;
               if ({1'b0, off} >= pop_cnt && {1'b0, off} < occ && q_index[i] == req_idx[p]) begin
                  coal_en[p]  = 1'b1;
                  coal_ptr[p] = PTR_W'(i);
               end
            end
            for (int j = 0; j < p; j++) begin
               if (push_en[j] && req_idx[j] == req_idx[p]) begin
                  coal_en[p]  = 1'b1;
                  coal_ptr[p] = push_ptr[j];
               end
            end
`endif
            if (!coal_en[p]) begin
               if (used < free) begin
                  push_en[p]  = 1'b1;
                  push_ptr[p] = tail + used[PTR_W-1:0];
                  used        = used + CNT_W'(1);
               end else begin
                  any_drop = 1'b1;
               end
            end
         end
      end
      push_cnt = used;
   end

   // Control FSM and queue pointers.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_INIT;
         init_idx   <= '0;
         head       <= '0;
         tail       <= '0;
         occ        <= '0;
         init_busy  <= 1'b1;
         drop_pulse <= 1'b0;
      end else if (bus.init_req) begin
         state      <= ST_INIT;
         init_idx   <= '0;
         head       <= '0;
         tail       <= '0;
         occ        <= '0;
         init_busy  <= 1'b1;
         drop_pulse <= 1'b0;
      end else begin
         drop_pulse <= any_drop;
         head       <= head + pop_cnt[PTR_W-1:0];
         tail       <= tail + push_cnt[PTR_W-1:0];
         occ        <= occ + push_cnt - pop_cnt;
         if (state == ST_INIT) begin
            init_idx <= init_idx + INDEX_W'(1);
            if (init_idx == INDEX_W'(ENTRY_NUM - 1)) begin
               state     <= ST_RUN;
               init_busy <= 1'b0;
            end
         end
      end
   end

   // NOTE: queue storage has no reset; an entry is only read after a push
   // has written it, and occupancy/pointers are what reset clears.
   always_ff @(posedge clk) begin
      for (int p = 0; p < REQ_NUM; p++) begin
         if (push_en[p]) begin
            q_index[push_ptr[p]] <= req_idx[p];
            q_data[push_ptr[p]]  <= req_dat[p];
         end
         // Later ports are written after earlier ones, so the higher port wins.
         if (coal_en[p]) q_data[coal_ptr[p]] <= req_dat[p];
      end
   end

   assign bus.wr_en      = wr_en;
   assign bus.wr_addr    = wr_addr;
   assign bus.wr_data    = wr_data;
   assign bus.init_busy  = init_busy;
   assign bus.drop_pulse = drop_pulse;
   assign bus.occupancy  = occ;

endmodule

// File: tb/tb_pht_update_scheduler.sv
// ---------------------------------------------------------------------------
// tb_pht_update_scheduler
//
// Self-checking bench for pht_update_scheduler with default parameters
// (1024 entries, 2 banks, 2 request ports, 2 write ports, 8-deep queue).
// Build with PHT_SCHED_COALESCE_EN defined to match a coalescing DUT.
// ---------------------------------------------------------------------------
module tb_pht_update_scheduler;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   pht_update_scheduler_if bus ();

   pht_update_scheduler dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_vec  = 0;
   int n_miss = 0;

   typedef struct {
      logic [9:0] idx;
      logic [7:0] data;
   } ent_t;

   ent_t mq[$];
   logic exp_drop = 1'b0;

   typedef struct {
      logic [1:0] v;
      logic [9:0] i0;
      logic [7:0] d0;
      logic [9:0] i1;
      logic [7:0] d1;
      logic [1:0] e_en;
      logic [9:0] e_a0;
      logic [7:0] e_d0;
      logic [9:0] e_a1;
      logic [7:0] e_d1;
      logic [3:0] e_occ;
   } vec_t;

   vec_t tbl[16];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [1:0] v, input logic [9:0] i0, input logic [9:0] i1,
                        input logic [7:0] d0, input logic [7:0] d1);
      bus.req_valid = v;
      bus.req_index = {i1, i0};
      bus.req_data  = {d1, d0};
   endtask

   // Checks one INIT sweep from address 0 to 1023. Random requests are
   // driven throughout and must be ignored. If restart_at >= 0, init_req is
   // pulsed once when that address is on the port.
   task automatic sweep(input int restart_at);
      int exp_a = 0;
      bit done = 1'b0;
      bit restarted = 1'b0;
      for (int c = 0; c < 2200 && !done; c++) begin
         check("sweep_port", {bus.wr_en, bus.wr_addr[9:0], bus.wr_data[7:0], bus.init_busy,
                              bus.occupancy, bus.drop_pulse},
               {2'b01, 10'(exp_a), 8'hAA, 1'b1, 4'd0, 1'b0});
         drive(2'b11, 10'($urandom), 10'($urandom), 8'($urandom), 8'($urandom));
         if (restart_at >= 0 && !restarted && exp_a == restart_at) begin
            bus.init_req = 1'b1;
            restarted    = 1'b1;
            exp_a        = 0;
         end else begin
            bus.init_req = 1'b0;
            if (exp_a == 1023) done = 1'b1;
            else exp_a++;
         end
         @(negedge clk);
      end
      check("sweep_done", 64'(done), 64'd1);
      drive(2'b00, '0, '0, '0, '0);
      bus.init_req = 1'b0;
      check("sweep_end", {bus.wr_en, bus.init_busy, bus.occupancy, bus.drop_pulse}, 64'd0);
   endtask

   // One RUN cycle against the queue model: compare this cycle's writes and
   // status, retire the issued entries, then apply and model new stimulus.
   task automatic sb_cycle(input logic [1:0] v, input logic [9:0] i0, input logic [9:0] i1,
                           input logic [7:0] d0, input logic [7:0] d1, input logic init);
      int n;
      bit ok;
      bit hit;
      logic [1:0] mask;
      logic [9:0] ri[2];
      logic [7:0] rd[2];
      n    = 0;
      mask = '0;
      for (int k = 0; k < 2; k++) begin
         if (n == k && k < mq.size()) begin
            ok = 1'b1;
            for (int j = 0; j < k; j++)
               if (mq[j].idx[0] == mq[k].idx[0]) ok = 1'b0;
            if (ok) begin
               mask[k] = 1'b1;
               n++;
            end
         end
      end
      check("sb_wr_en", bus.wr_en, mask);
      for (int k = 0; k < n; k++)
         check("sb_wr_entry", {bus.wr_addr[k*10 +: 10], bus.wr_data[k*8 +: 8]},
               {mq[k].idx, mq[k].data});
      check("sb_occupancy", bus.occupancy, 64'(mq.size()));
      check("sb_drop_pulse", bus.drop_pulse, exp_drop);
      for (int k = 0; k < n; k++) mq.delete(0);

      ri[0] = i0; ri[1] = i1;
      rd[0] = d0; rd[1] = d1;
      exp_drop = 1'b0;
      if (init) begin
         mq.delete();
      end else begin
         for (int p = 0; p < 2; p++) begin
            if (v[p]) begin
               hit = 1'b0;
`ifdef PHT_SCHED_COALESCE_EN
               foreach (mq[q]) begin
                  if (mq[q].idx == ri[p]) begin
                     mq[q].data = rd[p];
                     hit = 1'b1;
                  end
               end
`endif
               if (!hit) begin
                  if (mq.size() < 8) mq.push_back('{idx: ri[p], data: rd[p]});
                  else exp_drop = 1'b1;
               end
            end
         end
      end
      bus.init_req = init;
      drive(v, i0, i1, d0, d1);
      @(negedge clk);
   endtask

   task automatic drain();
      for (int c = 0; c < 20 && (mq.size() > 0 || exp_drop); c++)
         sb_cycle(2'b00, '0, '0, '0, '0, 1'b0);
      check("drain_empty", 64'(mq.size()), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      //            v      i0      d0     i1      d1     en     a0      d0     a1      d1     occ
      tbl[0]  = '{2'b11, 10'h004, 8'h01, 10'h005, 8'h02, 2'b11, 10'h004, 8'h01, 10'h005, 8'h02, 4'd2};
      tbl[1]  = '{2'b00, 10'h000, 8'h00, 10'h000, 8'h00, 2'b00, 10'h000, 8'h00, 10'h000, 8'h00, 4'd0};
      tbl[2]  = '{2'b11, 10'h006, 8'h03, 10'h008, 8'h04, 2'b01, 10'h006, 8'h03, 10'h000, 8'h00, 4'd2};
      tbl[3]  = '{2'b00, 10'h000, 8'h00, 10'h000, 8'h00, 2'b01, 10'h008, 8'h04, 10'h000, 8'h00, 4'd1};
      tbl[4]  = '{2'b00, 10'h000, 8'h00, 10'h000, 8'h00, 2'b00, 10'h000, 8'h00, 10'h000, 8'h00, 4'd0};
      tbl[5]  = '{2'b01, 10'h00A, 8'h05, 10'h000, 8'h00, 2'b01, 10'h00A, 8'h05, 10'h000, 8'h00, 4'd1};
      tbl[6]  = '{2'b10, 10'h000, 8'h00, 10'h00B, 8'h06, 2'b01, 10'h00B, 8'h06, 10'h000, 8'h00, 4'd1};
      tbl[7]  = '{2'b00, 10'h000, 8'h00, 10'h000, 8'h00, 2'b00, 10'h000, 8'h00, 10'h000, 8'h00, 4'd0};
      tbl[8]  = '{2'b11, 10'h00F, 8'h07, 10'h010, 8'h08, 2'b11, 10'h00F, 8'h07, 10'h010, 8'h08, 4'd2};
      tbl[9]  = '{2'b00, 10'h000, 8'h00, 10'h000, 8'h00, 2'b00, 10'h000, 8'h00, 10'h000, 8'h00, 4'd0};
`ifdef PHT_SCHED_COALESCE_EN
      tbl[10] = '{2'b11, 10'h00C, 8'h09, 10'h00C, 8'h0A, 2'b01, 10'h00C, 8'h0A, 10'h000, 8'h00, 4'd1};
      tbl[11] = '{2'b00, 10'h000, 8'h00, 10'h000, 8'h00, 2'b00, 10'h000, 8'h00, 10'h000, 8'h00, 4'd0};
`else
      tbl[10] = '{2'b11, 10'h00C, 8'h09, 10'h00C, 8'h0A, 2'b01, 10'h00C, 8'h09, 10'h000, 8'h00, 4'd2};
      tbl[11] = '{2'b00, 10'h000, 8'h00, 10'h000, 8'h00, 2'b01, 10'h00C, 8'h0A, 10'h000, 8'h00, 4'd1};
`endif
      tbl[12] = '{2'b00, 10'h000, 8'h00, 10'h000, 8'h00, 2'b00, 10'h000, 8'h00, 10'h000, 8'h00, 4'd0};
      tbl[13] = '{2'b11, 10'h011, 8'h0B, 10'h013, 8'h0C, 2'b01, 10'h011, 8'h0B, 10'h000, 8'h00, 4'd2};
      tbl[14] = '{2'b01, 10'h020, 8'h0D, 10'h000, 8'h00, 2'b11, 10'h013, 8'h0C, 10'h020, 8'h0D, 4'd2};
      tbl[15] = '{2'b00, 10'h000, 8'h00, 10'h000, 8'h00, 2'b00, 10'h000, 8'h00, 10'h000, 8'h00, 4'd0};

      rst          = 1'b1;
      bus.init_req = 1'b0;
      drive(2'b00, '0, '0, '0, '0);
      repeat (2) @(negedge clk);
      check("reset_state", {bus.wr_en, bus.init_busy, bus.drop_pulse, bus.occupancy},
            {2'b00, 1'b1, 1'b0, 4'd0});

      // Power-on sweep.
      rst = 1'b0;
      #1;
      sweep(-1);

      // Directed single-cycle vectors.
      for (int r = 0; r < 16; r++) begin
         drive(tbl[r].v, tbl[r].i0, tbl[r].i1, tbl[r].d0, tbl[r].d1);
         @(negedge clk);
         check($sformatf("tbl%0d_wr_en", r), bus.wr_en, tbl[r].e_en);
         if (tbl[r].e_en[0])
            check($sformatf("tbl%0d_port0", r), {bus.wr_addr[9:0], bus.wr_data[7:0]},
                  {tbl[r].e_a0, tbl[r].e_d0});
         if (tbl[r].e_en[1])
            check($sformatf("tbl%0d_port1", r), {bus.wr_addr[19:10], bus.wr_data[15:8]},
                  {tbl[r].e_a1, tbl[r].e_d1});
         check($sformatf("tbl%0d_occupancy", r), bus.occupancy, tbl[r].e_occ);
         check($sformatf("tbl%0d_drop_pulse", r), bus.drop_pulse, 1'b0);
      end

      // Saturation: ten cycles of same-bank pairs at distinct indices.
      for (int i = 0; i < 10; i++)
         sb_cycle(2'b11, 10'h040 + 10'(i*4), 10'h042 + 10'(i*4), 8'(i*2), 8'(i*2+1), 1'b0);
      drain();

      // Second request to 0x010 arrives while the first is stuck behind 0x012.
      sb_cycle(2'b11, 10'h012, 10'h010, 8'h33, 8'h11, 1'b0);
      sb_cycle(2'b01, 10'h010, 10'h000, 8'h22, 8'h00, 1'b0);
      drain();

      // Mixed traffic on a small index window: conflicts, repeats, drops.
      for (int c = 0; c < 40; c++)
         sb_cycle(2'($urandom_range(0, 3)), 10'h030 + 10'($urandom_range(0, 7)),
                  10'h030 + 10'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'b0);
      drain();

      // Flush with five queued entries, then a sweep restarted part way.
      for (int i = 0; i < 4; i++)
         sb_cycle(2'b11, 10'h080 + 10'(i*8), 10'h084 + 10'(i*8), 8'h50 + 8'(i), 8'h60 + 8'(i), 1'b0);
      check("pre_flush_occupancy", bus.occupancy, 64'd5);
      sb_cycle(2'b00, '0, '0, '0, '0, 1'b1);
      check("flush_occupancy", bus.occupancy, 64'd0);
      check("flush_init_busy", bus.init_busy, 64'd1);
      sweep(20);

      // Normal operation resumes after the flush.
      exp_drop = 1'b0;
      sb_cycle(2'b11, 10'h004, 10'h005, 8'h77, 8'h88, 1'b0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
